state_packer: RTL and testbench
===============================

# state_packer

Sequential, parametrised successor to the combinational packing stage in the vector AES datapath. It accumulates 32-bit ALU lane results over one or more beats into a full 128-bit AES state, in row-major or MixColumns (transposed) byte order. It presents that state to the state register / next round stage through a valid/ready handshake. It sits between the vector ALU lanes and the round-state register and supports 1, 2 or 4 ALU lanes per beat.

## Interface

Parameters:
- LANES, 2, 32-bit ALU results delivered per beat. Legal values are 1, 2 and 4; any other value is a compile-time error.
- BEATS, 4/LANES, derived, not overridable: beats per 128-bit state.

Ports:
- clk  input  1  single clock; all state updates on the rising edge.
- rst  input  1  reset, synchronous and active-high.
- clr  input  1  synchronous flush of the partial fill and the held output; lower priority than rst.
- in_valid  input  1  beat offered.
- in_ready  output  1  beat can be accepted this cycle.
- alu_result  input  LANES*32  lane l occupies bits [32l+31:32l]; lane 0 is the lowest word index.
- mc_mode  input  1  1 = MixColumns/transposed packing, 0 = row-major; sampled on the first beat only.
- out_valid  output  1  packed_state holds a complete state.
- out_ready  input  1  consumer takes the state.
- packed_state  output  128  state bytes s[0..15]; s[0] = bits [127:120], s[15] = bits [7:0].
- out_mc_mode  output  1  mode the held state was packed with.
- out_parity  output  16  only with STATE_PACKER_PARITY_EN; even parity of s[i] on bit 15-i.

## Operation

- Beat accepted when in_valid && in_ready. A beat counter beat_cnt runs 0..BEATS-1.
- Word index is w = beat_cnt*LANES + l. Byte b of a word is numbered 0..3, with b=0 the most significant byte.
- Row-major (mode 0): word w byte b is written to s[4w+b].
- Transposed (mode 1): word w byte b is written to s[4b+w].
- Mode latch: mc_mode is captured when beat_cnt==0. Later beats of the same state ignore mc_mode.
- FSM has two states:
  - FILL: accepting beats. On the final beat, beat_cnt wraps to 0, the assembled state is copied into the output register and the FSM goes to FULL.
  - FULL: out_valid=1, output held stable. On out_ready the FSM returns to FILL, unless a final beat is accepted in the same cycle, in which case it stays in FULL with the new state loaded.
- in_ready = (state==FILL) || out_ready. Accumulation of the next state may proceed while FULL only in a cycle where out_ready=1; beats are never dropped or overwritten.
- When BEATS==1 (LANES=4), every accepted beat is a final beat.
- Bytes of a partial fill not yet written keep stale values. They are never visible, because the output register loads only on the final beat, and all 16 bytes are written by then.
- clr: beat_cnt←0, FSM←FILL, out_valid←0. packed_state holds its value. Beats offered in the clr cycle are discarded, and in_ready is 0 during clr.
- rst: beat_cnt←0, FSM←FILL, packed_state←0, out_mc_mode←0, out_parity←0.

## Timing

- Reset values: in_ready=1, out_valid=0, packed_state=128'h0, out_mc_mode=0, out_parity=16'h0.
- Latency: out_valid rises the cycle after the final beat is accepted.
- Throughput: one state per BEATS cycles when out_ready is held at 1, with no bubbles.
- Output stability: packed_state, out_mc_mode and out_parity must not change while out_valid=1 && out_ready=0.
- No combinational path from in_valid or alu_result to any output. in_ready depends combinationally on out_ready only.
- rst or clr asserted mid-fill abandons the partial state. The next accepted beat is beat 0 and re-samples mc_mode.

## Configuration

- STATE_PACKER_PARITY_EN defined:
  - out_parity exists and is registered alongside packed_state, in the same load cycle.
  - out_parity[15-i] = ^s[i].
- STATE_PACKER_PARITY_EN undefined:
  - the out_parity port and its logic are absent.
  - All other behaviour is identical.

## Test plan

- LANES=2, mode 0, beats {0x05060708,0x01020304} then {0x0d0e0f10,0x090a0b0c} (bus shown lane1,lane0), out_ready=1 -> packed_state=0x0102030405060708090a0b0c0d0e0f10, out_valid for 1 cycle, latency 1 after beat 2.
- Same data, mc_mode=1 on beat 0 and mc_mode=0 on beat 1 -> 0x0105090d02060a0e03070b0f04080c10, out_mc_mode=1 (mode latched).
- out_ready=0 after first state -> out_valid and data held. in_ready=0; in_valid held high accepts no beats. Raise out_ready together with the next final beat -> the new state loads the following cycle and out_valid stays 1 continuously.
- LANES=4, one beat 0x0d0e0f10_090a0b0c_05060708_01020304 per cycle, out_ready=1 -> a new state every cycle, full throughput.
- LANES=1: clr after 2 of 4 beats, then 4 fresh beats 0xAABBCCDD..0x11223344 -> only the fresh beats appear. rst mid-fill -> packed_state=0, out_valid=0.
- With STATE_PACKER_PARITY_EN: state with s[0]=0x01 and all other bytes 0x03 -> out_parity=16'h8000.

Source files
------------

// File: rtl/state_packer.sv
`timescale 1ns/1ps
// state_packer
// Accumulates LANES x 32-bit ALU lane results per beat into one 128-bit AES
// state, in row-major or MixColumns (transposed) byte order. The finished
// state is held in an output register and offered downstream over valid/ready.
//
// Parameters:
//   LANES        32-bit results per beat (1, 2 or 4); BEATS = 4/LANES is derived
// Ports:
//   clk          rising-edge clock
//   rst          synchronous active-high reset
//   clr          synchronous flush of partial fill and held output
//   in_valid_i   -> in_valid     beat offered
//   in_ready     beat accepted this cycle (combinational on out_ready/clr)
//   alu_result   lane l in bits [32l+31:32l]
//   mc_mode      1 = transposed packing; sampled on beat 0 only
//   out_valid    packed_state holds a complete state
//   out_ready    consumer takes the state
//   packed_state s[0] = bits [127:120] ... s[15] = bits [7:0]
//   out_mc_mode  packing mode of the held state
//   out_parity   (STATE_PACKER_PARITY_EN only) even parity of s[i] on bit 15-i
//
// Optional feature macro: STATE_PACKER_PARITY_EN
module state_packer #(
    parameter int unsigned LANES = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 clr,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [LANES*32-1:0]  alu_result,
    input  logic                 mc_mode,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [127:0]         packed_state,
    output logic                 out_mc_mode
`ifdef STATE_PACKER_PARITY_EN
    ,
    output logic [15:0]          out_parity
`endif
);

    localparam int unsigned BEATS = 4 / LANES;
    localparam int unsigned CNT_W = (BEATS > 1) ? $clog2(BEATS) : 1;

    // Reject unsupported lane counts at elaboration.
    if (!(LANES == 1 || LANES == 2 || LANES == 4)) begin : g_bad_lanes
        $error("state_packer: LANES must be 1, 2 or 4");
    end

    typedef enum logic {
        ST_FILL = 1'b0,
        ST_FULL = 1'b1
    } state_e;

    state_e             state_q;
    logic [CNT_W-1:0]   beat_cnt_q;
    logic [127:0]       acc_q;
    logic [127:0]       acc_d;
    logic               mode_q;
    logic [127:0]       pk_q;
    logic               omode_q;

    logic               accept;
    logic               final_beat;
    logic               cur_mode;
    int                 w_idx;
    int                 s_idx;

`ifdef STATE_PACKER_PARITY_EN
    logic [15:0]        par_q;
    logic [15:0]        par_d;
`endif

    // Handshake: a FULL state blocks input unless it is consumed this cycle.
    always_comb begin
        in_ready   = !clr && ((state_q == ST_FILL) || out_ready);
        accept     = in_valid && in_ready;
        final_beat = (beat_cnt_q == CNT_W'(BEATS - 1));
        // Beat 0 takes the live mode; later beats use the latched one.
        cur_mode   = (beat_cnt_q == '0) ? mc_mode : mode_q;
    end

    // Scatter this beat's bytes into the assembly buffer.
    always_comb begin
        acc_d = acc_q;
        w_idx = 0;
        s_idx = 0;
        for (int l = 0; l < int'(LANES); l++) begin
            for (int b = 0; b < 4; b++) begin
                w_idx = int'(beat_cnt_q) * int'(LANES) + l;
                s_idx = cur_mode ? (4 * b + w_idx) : (4 * w_idx + b);
                acc_d[127 - 8 * s_idx -: 8] = alu_result[32 * l + 31 - 8 * b -: 8];
            end
        end
    end

`ifdef STATE_PACKER_PARITY_EN
    // Per-byte even parity of the state being loaded.
    always_comb begin
        par_d = '0;
        for (int i = 0; i < 16; i++) begin
            par_d[15 - i] = ^acc_d[127 - 8 * i -: 8];
        end
    end
`endif

    // FSM, beat counter and datapath registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_FILL;
            beat_cnt_q <= '0;
            acc_q      <= '0;
            mode_q     <= 1'b0;
            pk_q       <= '0;
            omode_q    <= 1'b0;
`ifdef STATE_PACKER_PARITY_EN
            par_q      <= '0;
`endif
        end else if (clr) begin
            // Abandon the partial fill; the held output data is kept.
            state_q    <= ST_FILL;
            beat_cnt_q <= '0;
        end else begin
            if (accept) begin
                acc_q <= acc_d;
                if (beat_cnt_q == '0) begin
                    mode_q <= mc_mode;
                end
                if (final_beat) begin
                    beat_cnt_q <= '0;
                    pk_q       <= acc_d;
                    omode_q    <= cur_mode;
`ifdef STATE_PACKER_PARITY_EN
                    par_q      <= par_d;
`endif
                end else begin
                    beat_cnt_q <= beat_cnt_q + CNT_W'(1);
                end
            end

            case (state_q)
                ST_FILL: begin
                    if (accept && final_beat) begin
                        state_q <= ST_FULL;
                    end
                end
                ST_FULL: begin
                    // A final beat accepted during consumption reloads and stays FULL.
                    if (out_ready && !(accept && final_beat)) begin
                        state_q <= ST_FILL;
                    end
                end
                default: state_q <= ST_FILL;
            endcase
        end
    end

    assign out_valid    = (state_q == ST_FULL);
    assign packed_state = pk_q;
    assign out_mc_mode  = omode_q;
`ifdef STATE_PACKER_PARITY_EN
    assign out_parity   = par_q;
`endif

endmodule

// File: tb/tb_state_packer.sv
`timescale 1ns/1ps
// Self-checking bench for state_packer: LANES=1, 2 and 4 instances side by
// side. Stimulus pushes hand-computed expected states into per-instance
// queues; monitors pop and compare on every output handshake.
module tb_state_packer;

    typedef struct {
        logic [127:0] d;
        logic         m;
        logic [15:0]  p;
        bit           pc;
    } exp_t;

    localparam logic [127:0] E0 = 128'h0102030405060708090a0b0c0d0e0f10;
    localparam logic [127:0] T0 = 128'h0105090d02060a0e03070b0f04080c10;
    localparam logic [127:0] W0 = 128'h11111111222222223333333344444444;
    localparam logic [127:0] W1 = 128'h11223344112233441122334411223344;
    localparam logic [127:0] V4 = 128'h0d0e0f10090a0b0c0506070801020304;
    localparam logic [127:0] X4 = 128'h44444444333333332222222211111111;
    localparam logic [127:0] P4 = 128'h03030303030303030303030301030303;
    localparam logic [127:0] PE = 128'h01030303030303030303030303030303;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst, clr;
    logic iv1, ir1, mc1, ov1, or1, om1;
    logic iv2, ir2, mc2, ov2, or2, om2;
    logic iv4, ir4, mc4, ov4, or4, om4;
    logic [31:0]  a1;
    logic [63:0]  a2;
    logic [127:0] a4;
    logic [127:0] ps1, ps2, ps4;
    logic [15:0]  p1, p2, p4;

    exp_t q1[$];
    exp_t q2[$];
    exp_t q4[$];

    int n_cmp = 0;
    int n_bad = 0;

    state_packer #(.LANES(1)) u_l1 (
        .clk(clk), .rst(rst), .clr(clr), .in_valid(iv1), .in_ready(ir1),
        .alu_result(a1), .mc_mode(mc1), .out_valid(ov1), .out_ready(or1),
        .packed_state(ps1), .out_mc_mode(om1)
`ifdef STATE_PACKER_PARITY_EN
        , .out_parity(p1)
`endif
    );

    state_packer #(.LANES(2)) u_l2 (
        .clk(clk), .rst(rst), .clr(clr), .in_valid(iv2), .in_ready(ir2),
        .alu_result(a2), .mc_mode(mc2), .out_valid(ov2), .out_ready(or2),
        .packed_state(ps2), .out_mc_mode(om2)
`ifdef STATE_PACKER_PARITY_EN
        , .out_parity(p2)
`endif
    );

    state_packer #(.LANES(4)) u_l4 (
        .clk(clk), .rst(rst), .clr(clr), .in_valid(iv4), .in_ready(ir4),
        .alu_result(a4), .mc_mode(mc4), .out_valid(ov4), .out_ready(or4),
        .packed_state(ps4), .out_mc_mode(om4)
`ifdef STATE_PACKER_PARITY_EN
        , .out_parity(p4)
`endif
    );

`ifndef STATE_PACKER_PARITY_EN
    assign p1 = 16'h0;
    assign p2 = 16'h0;
    assign p4 = 16'h0;
`endif

    function automatic void chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, want %h", nm, act, exp);
        end
    endfunction

    function automatic exp_t mk(input logic [127:0] d, input logic m, input logic [15:0] p, input bit pc);
        exp_t e;
        e.d  = d;
        e.m  = m;
        e.p  = p;
`ifdef STATE_PACKER_PARITY_EN
        e.pc = pc;
`else
        e.pc = 1'b0;
`endif
        return e;
    endfunction

    function automatic void cmp_out(input string nm, input exp_t e, input logic [127:0] d,
                                    input logic m, input logic [15:0] p);
        chk({nm, "_data"}, d, e.d);
        chk({nm, "_mode"}, 128'(m), 128'(e.m));
        if (e.pc) chk({nm, "_parity"}, 128'(p), 128'(e.p));
    endfunction

    function automatic void sb_empty(input string nm);
        n_cmp++;
        n_bad++;
        $display("FAIL %s: output presented, scoreboard empty", nm);
    endfunction

    // Monitors: a handshake happens at the next rising edge when valid && ready.
    always @(negedge clk) begin
        if (!rst && !clr && ov1 && or1) begin
            if (q1.size() == 0) sb_empty("l1_out");
            else cmp_out("l1_out", q1.pop_front(), ps1, om1, p1);
        end
    end

    always @(negedge clk) begin
        if (!rst && !clr && ov2 && or2) begin
            if (q2.size() == 0) sb_empty("l2_out");
            else cmp_out("l2_out", q2.pop_front(), ps2, om2, p2);
        end
    end

    always @(negedge clk) begin
        if (!rst && !clr && ov4 && or4) begin
            if (q4.size() == 0) sb_empty("l4_out");
            else cmp_out("l4_out", q4.pop_front(), ps4, om4, p4);
        end
    end

    // Offer one beat and wait (bounded) for acceptance; returns at posedge+1.
    task automatic beat1(input logic [31:0] d, input logic m);
        int n;
        n = 0;
        iv1 = 1'b1; a1 = d; mc1 = m;
        @(negedge clk);
        while (!ir1 && n < 50) begin n++; @(negedge clk); end
        if (!ir1) begin n_cmp++; n_bad++; $display("FAIL l1_accept_timeout: in_ready 0, want 1"); end
        @(posedge clk); #1;
        iv1 = 1'b0;
    endtask

    task automatic beat2(input logic [63:0] d, input logic m);
        int n;
        n = 0;
        iv2 = 1'b1; a2 = d; mc2 = m;
        @(negedge clk);
        while (!ir2 && n < 50) begin n++; @(negedge clk); end
        if (!ir2) begin n_cmp++; n_bad++; $display("FAIL l2_accept_timeout: in_ready 0, want 1"); end
        @(posedge clk); #1;
        iv2 = 1'b0;
    endtask

    logic [127:0] v4 [4];
    logic         m4 [4];
    logic [127:0] e4 [4];

    initial begin
        v4[0] = V4; m4[0] = 1'b0; e4[0] = E0;
        v4[1] = V4; m4[1] = 1'b1; e4[1] = T0;
        v4[2] = X4; m4[2] = 1'b0; e4[2] = W0;
        v4[3] = X4; m4[3] = 1'b1; e4[3] = W1;

        rst = 1'b1; clr = 1'b0;
        iv1 = 1'b0; iv2 = 1'b0; iv4 = 1'b0;
        mc1 = 1'b0; mc2 = 1'b0; mc4 = 1'b0;
        or1 = 1'b1; or2 = 1'b1; or4 = 1'b1;
        a1 = '0; a2 = '0; a4 = '0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        // Reset values
        @(negedge clk);
        chk("rst_l2_in_ready", 128'(ir2), 128'd1);
        chk("rst_l2_out_valid", 128'(ov2), 128'd0);
        chk("rst_l2_packed", ps2, 128'h0);
        chk("rst_l2_mode", 128'(om2), 128'd0);
        chk("rst_l1_in_ready", 128'(ir1), 128'd1);
        chk("rst_l4_out_valid", 128'(ov4), 128'd0);
        chk("rst_l4_parity", 128'(p4), 128'd0);
        @(posedge clk); #1;

        // LANES=2 row-major, latency and single-cycle valid
        q2.push_back(mk(E0, 1'b0, 16'h0, 1'b0));
        beat2(64'h05060708_01020304, 1'b0);
        chk("l2_no_early_valid", 128'(ov2), 128'd0);
        beat2(64'h0d0e0f10_090a0b0c, 1'b0);
        @(negedge clk);
        chk("l2_latency", 128'(ov2), 128'd1);
        @(negedge clk);
        chk("l2_valid_one_cycle", 128'(ov2), 128'd0);
        @(posedge clk); #1;

        // LANES=2 transposed, mode latched from beat 0
        q2.push_back(mk(T0, 1'b1, 16'h0, 1'b0));
        beat2(64'h05060708_01020304, 1'b1);
        beat2(64'h0d0e0f10_090a0b0c, 1'b0);
        @(negedge clk);
        @(posedge clk); #1;

        // LANES=2 stall: output held, no beats accepted
        or2 = 1'b0;
        q2.push_back(mk(W0, 1'b0, 16'h0, 1'b0));
        beat2(64'h22222222_11111111, 1'b0);
        beat2(64'h44444444_33333333, 1'b0);
        iv2 = 1'b1; a2 = 64'h05060708_01020304; mc2 = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("l2_stall_valid", 128'(ov2), 128'd1);
            chk("l2_stall_in_ready", 128'(ir2), 128'd0);
            chk("l2_stall_data", ps2, W0);
            @(posedge clk); #1;
        end
        q2.push_back(mk(T0, 1'b1, 16'h0, 1'b0));
        or2 = 1'b1;
        @(posedge clk); #1;
        a2 = 64'h0d0e0f10_090a0b0c; mc2 = 1'b0;
        @(posedge clk); #1;
        iv2 = 1'b0;
        @(negedge clk);
        @(posedge clk); #1;

        // LANES=4 full throughput
        for (int k = 0; k < 4; k++) begin
            q4.push_back(mk(e4[k], m4[k], 16'h0, 1'b0));
            iv4 = 1'b1; a4 = v4[k]; mc4 = m4[k];
            @(negedge clk);
            chk("l4_tput_in_ready", 128'(ir4), 128'd1);
            if (k > 0) chk("l4_tput_valid", 128'(ov4), 128'd1);
            @(posedge clk); #1;
        end
        iv4 = 1'b0;
        @(negedge clk);
        chk("l4_tput_last_valid", 128'(ov4), 128'd1);
        @(negedge clk);
        chk("l4_tput_drained", 128'(ov4), 128'd0);
        @(posedge clk); #1;

        // LANES=4 stall, then release together with the next final beat
        or4 = 1'b0;
        q4.push_back(mk(PE, 1'b0, 16'h8000, 1'b1));
        iv4 = 1'b1; a4 = P4; mc4 = 1'b0;
        @(posedge clk); #1;
        a4 = V4;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("l4_stall_valid", 128'(ov4), 128'd1);
            chk("l4_stall_in_ready", 128'(ir4), 128'd0);
            chk("l4_stall_data", ps4, PE);
            @(posedge clk); #1;
        end
        q4.push_back(mk(E0, 1'b0, 16'h0, 1'b0));
        or4 = 1'b1;
        @(posedge clk); #1;
        iv4 = 1'b0;
        @(negedge clk);
        chk("l4_valid_continuous", 128'(ov4), 128'd1);
        @(posedge clk); #1;

        // LANES=1 clr mid-fill; clr-cycle beat discarded
        beat1(32'hdeadbeef, 1'b1);
        beat1(32'hcafef00d, 1'b0);
        clr = 1'b1; iv1 = 1'b1; a1 = 32'hffffffff; mc1 = 1'b1;
        @(negedge clk);
        chk("l1_clr_in_ready", 128'(ir1), 128'd0);
        @(posedge clk); #1;
        clr = 1'b0; iv1 = 1'b0;
        q1.push_back(mk(128'haabbccdd_99887766_55443322_11223344, 1'b0, 16'h0, 1'b0));
        beat1(32'haabbccdd, 1'b0);
        beat1(32'h99887766, 1'b1);
        beat1(32'h55443322, 1'b1);
        beat1(32'h11223344, 1'b1);
        @(negedge clk);
        chk("l1_clr_refill_valid", 128'(ov1), 128'd1);
        @(posedge clk); #1;

        // LANES=1 rst mid-fill
        beat1(32'h01020304, 1'b0);
        beat1(32'h05060708, 1'b0);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        chk("l1_rst_packed", ps1, 128'h0);
        chk("l1_rst_valid", 128'(ov1), 128'd0);
        chk("l2_rst_packed", ps2, 128'h0);
        @(posedge clk); #1;
        q1.push_back(mk(T0, 1'b1, 16'h0, 1'b0));
        beat1(32'h01020304, 1'b1);
        beat1(32'h05060708, 1'b0);
        beat1(32'h090a0b0c, 1'b0);
        beat1(32'h0d0e0f10, 1'b0);
        @(negedge clk);
        chk("l1_rst_refill_mode", 128'(om1), 128'd1);

        repeat (3) @(negedge clk);
        chk("l1_sb_drained", 128'(q1.size()), 128'd0);
        chk("l2_sb_drained", 128'(q2.size()), 128'd0);
        chk("l4_sb_drained", 128'(q4.size()), 128'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached, want completion");
        $fatal(1, "watchdog");
    end

endmodule
